// File: rtl/acc_requant_pkg.sv
// Shared definitions for the accumulate-and-requantise block: FSM encoding and default widths.
package acc_requant_pkg;

   localparam int CW_DEF = 17;
   localparam int AW_DEF = 24;
   localparam int OW_DEF = 8;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_e;

endpackage

// File: rtl/acc_requant_requant_sat.sv
// Combinational round-half-up right shift, optional ReLU and saturation to OW bits.
// ReLU is only built when ACC_REQUANT_RELU_EN is defined.
module requant_sat
   import acc_requant_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int OW = OW_DEF
) (
   input  logic [AW-1:0] acc_in,
   input  logic [4:0]    shift,
   input  logic          relu_en,
   output logic [OW-1:0] q_out
);

   logic signed [AW:0] ext;
   logic signed [AW:0] rnd;
   logic signed [AW:0] sum_r;
   logic signed [AW:0] r;
   logic [AW-OW+1:0]   hi;

`ifndef ACC_REQUANT_RELU_EN
   logic unused_relu;
   assign unused_relu = relu_en;
`endif

   always_comb begin
      ext   = $signed({acc_in[AW-1], acc_in});
      rnd   = $signed({{AW{1'b0}}, 1'b1} << (shift - 5'd1));
      sum_r = ext + rnd;
      r     = (shift == 5'd0) ? ext : (sum_r >>> shift);
`ifdef ACC_REQUANT_RELU_EN
      if (relu_en && r[AW]) begin
         r = '0;
      end
`endif
      // In range only when every bit above the output sign bit matches it.
      hi = r[AW:OW-1];
      if (hi == '0 || hi == '1) begin
         q_out = r[OW-1:0];
      end else if (r[AW]) begin
         q_out = {1'b1, {(OW-1){1'b0}}};
      end else begin
         q_out = {1'b0, {(OW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/acc_requant.sv
// Accumulates signed partial products per vector, then requantises the sum on the last beat.
// Optional ReLU: define ACC_REQUANT_RELU_EN.
module acc_requant
   import acc_requant_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int AW = AW_DEF,
   parameter int OW = OW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_data,
   input  logic             in_last,
   input  logic [4:0]       shift,
   input  logic             relu_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OW-1:0]    out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_cnt
);

   state_e             state_q, state_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [OW-1:0]      out_data_q, out_data_d;
   logic               out_ovf_q, out_ovf_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

   logic               accept;
   logic               in_vec;
   logic [AW-1:0]      acc_base;
   logic [AW:0]        sum;
   logic               acc_ovf;
   logic [AW-1:0]      acc_next;
   logic               ovf_next;
   logic [CNT_W-1:0]   cnt_base;
   logic [CNT_W-1:0]   cnt_next;
   logic [OW-1:0]      req_data;

   // A beat while S_ACC extends the vector; any other accepted beat starts a fresh one.
   always_comb begin
      in_ready = !rst && ((state_q != S_OUT) || out_ready);
      accept   = in_valid && in_ready;
      in_vec   = (state_q == S_ACC);
      acc_base = in_vec ? acc_q : '0;
      sum      = {acc_base[AW-1], acc_base} + {{(AW+1-CW){in_data[CW-1]}}, in_data};
      acc_ovf  = sum[AW] ^ sum[AW-1];
      if (!acc_ovf) begin
         acc_next = sum[AW-1:0];
      end else if (sum[AW]) begin
         acc_next = {1'b1, {(AW-1){1'b0}}};
      end else begin
         acc_next = {1'b0, {(AW-1){1'b1}}};
      end
      ovf_next = (in_vec && ovf_q) || acc_ovf;
      cnt_base = in_vec ? cnt_q : '0;
      cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + 16'd1;
   end

   requant_sat #(.AW(AW), .OW(OW)) u_requant_sat (
      .acc_in  (acc_next),
      .shift   (shift),
      .relu_en (relu_en),
      .q_out   (req_data)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      out_cnt_d   = out_cnt_q;
      if (state_q == S_OUT && out_ready) begin
         out_valid_d = 1'b0;
         state_d     = S_IDLE;
      end
      if (accept) begin
         acc_d = acc_next;
         ovf_d = ovf_next;
         cnt_d = cnt_next;
         if (in_last) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_data_d  = req_data;
            out_ovf_d   = ovf_next;
            out_cnt_d   = cnt_next;
         end else begin
            state_d = S_ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_cnt   = out_cnt_q;

endmodule

// File: doc/acc_requant.md
ACC_REQUANT -- requirements
Module: acc_requant

Interface
REQ-001 SHALL have parameter CW, default 17: signed input width, matching macu co.
REQ-002 SHALL have parameter AW, default 24: signed accumulator width, AW > CW.
REQ-003 SHALL have parameter OW, default 8: signed output width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  in_data beat valid.
REQ-008 in_ready  output  1  block accepts a beat.
REQ-009 in_data  input  CW  signed partial product, from macu co.
REQ-010 in_last  input  1  final beat of the current dot product.
REQ-011 shift  input  5  right-shift amount, sampled on the accepted last beat.
REQ-012 relu_en  input  1  ReLU enable, sampled on the accepted last beat.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  OW  signed requantised result.
REQ-016 out_ovf  output  1  accumulator saturated during this vector.
REQ-017 out_cnt  output  16  beats in this vector.

Function
REQ-018 A beat SHALL be accepted when in_valid && in_ready, with in_ready = (state != S_OUT) || out_ready.
REQ-019 The FSM SHALL have three states:
- S_IDLE to S_ACC on an accepted non-last beat.
- S_IDLE or S_ACC to S_OUT on an accepted last beat.
- S_OUT to S_IDLE on out_ready with no accepted beat.
- S_OUT to S_ACC or S_OUT on out_ready with a simultaneously accepted beat, chosen by that beat's in_last.
REQ-020 Accumulation: acc_next = (state == S_ACC ? acc : 0) + sext(in_data). The sum SHALL saturate at the AW signed limits and set a sticky ovf for the vector.
REQ-021 Requant of acc_next on the last beat:
- r = (shift == 0) ? acc_next : (acc_next + 2^(shift-1)) >>> shift, an arithmetic shift computed at AW+1 bits.
- Optional ReLU per REQ-031/032.
- Saturate to [-2^(OW-1), 2^(OW-1)-1].
REQ-022 Latency: out_valid SHALL assert in the cycle after the last beat is accepted.
REQ-023 out_data, out_ovf and out_cnt SHALL be held stable while out_valid && !out_ready.
REQ-024 out_cnt SHALL count accepted beats including the last, saturating at 0xFFFF.
REQ-025 A single-beat vector (in_last on its first beat) SHALL be valid and give out_cnt = 1.
REQ-026 ovf and the beat count SHALL clear at the start of each vector.

Reset
REQ-027 rst SHALL force state = S_IDLE, acc = 0, ovf = 0, cnt = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_cnt = 0.
REQ-028 Reset mid-vector SHALL discard the partial sum. The first post-reset beat SHALL start a new vector.
REQ-029 While rst is high, in_ready SHALL be 0.

Configuration
REQ-030 Macro ACC_REQUANT_RELU_EN SHALL be the only compile-time option.
REQ-031 With ACC_REQUANT_RELU_EN defined: when relu_en = 1, r < 0 SHALL become 0 before saturation.
REQ-032 Without ACC_REQUANT_RELU_EN: relu_en SHALL be ignored and no ReLU logic built.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding (S_IDLE, S_ACC, S_OUT) and the default widths.
REQ-034 The round/shift/saturate path SHALL be one combinational sub-module, requant_sat.

Verification
REQ-035 Rounding: beats 100, 200, -50(last), shift = 2 -> out_data = 63, out_cnt = 3, out_ovf = 0, one cycle after the last beat.
REQ-036 Saturation: single beat 1000(last), shift = 0 -> out_data = 127. Beat -65536(last), shift = 0 -> out_data = -128.
REQ-037 ReLU: beat -300(last), shift = 1:
- relu_en = 1 with the macro -> out_data = 0.
- Without the macro -> out_data = -128 (r = -150).
REQ-038 Backpressure: out_ready = 0 for 5 cycles:
- in_ready = 0 and out_data stable throughout.
- On out_ready = 1, a simultaneously offered beat 7(last) is accepted; next output = 7.
REQ-039 Accumulator overflow: AW = 18 and four beats of 65535 -> acc saturates at 131071, out_ovf = 1. The following vector reports out_ovf = 0.
REQ-040 Reset mid-vector: beats 500, 500, then rst, then beat 3(last), shift = 0 -> out_data = 3, out_cnt = 1.
